// File: rtl/sram_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sram_mem_arbiter
//
// Shares one sram-like memory request/response port between the instruction
// fetch requester (IF stage) and the load/store requester (MEM stage).
// Only one transaction is in flight at a time. Data side has priority; a
// bounded streak counter forces a fetch grant after MAX_DATA_STREAK
// consecutive contested data grants so fetch cannot starve.
//
// State table:
//   IDLE  | no transaction; arbitrate and accept a request (addr_ok)
//   ISSUE | mem_req high with latched fields, waiting for mem_req_ready
//   WAIT  | request taken downstream, waiting for mem_resp_valid
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   inst_req/inst_addr           fetch request (word read)
//   inst_addr_ok/inst_data_ok    fetch accept / fetch response strobe
//   inst_rdata                   fetch read data (valid with inst_data_ok)
//   data_req/wr/size/wstrb/addr/wdata   load/store request
//   data_addr_ok/data_data_ok    load/store accept / response strobe
//   data_rdata                   load read data (valid with data_data_ok)
//   mem_req/wr/size/wstrb/addr/wdata    downstream request (registered)
//   mem_req_ready                downstream accepts the request
//   mem_resp_valid/mem_resp_rdata downstream response
//   busy                         a transaction is in progress
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);
    localparam logic [3:0] STREAK_MAX   = 4'hF;

    state_t     state;
    logic       owner_data;     // 0 = fetch owns the transaction, 1 = load/store
    logic [3:0] streak;
    logic       mem_req_q;
    logic       busy_q;

    logic       force_inst;
    logic       grant_inst;
    logic       grant_data;
    logic       resp_fire;

    // Arbitration is combinational so the winner sees addr_ok in the same
    // cycle it presents the request. Gated by resetn so nothing is accepted
    // while reset is being applied.
    always_comb begin
        force_inst = (MAX_DATA_STREAK != 0) && (streak == STREAK_LIMIT);
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn && (state == S_IDLE)) begin
            if (inst_req && data_req) begin
                grant_inst = force_inst;
                grant_data = !force_inst;
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    // Responses outside WAIT are stray and never reach a requester.
    assign resp_fire    = resetn && (state == S_WAIT) && mem_resp_valid;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp_fire && !owner_data;
    assign data_data_ok = resp_fire &&  owner_data;
    assign inst_rdata   = mem_resp_rdata;
    assign data_rdata   = mem_resp_rdata;

    assign mem_req      = mem_req_q;
    assign busy         = busy_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner_data <= 1'b0;
            streak     <= 4'd0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_size   <= 2'd0;
            mem_wstrb  <= 4'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_inst) begin
                        // Fetch is always a plain word read.
                        mem_wr     <= 1'b0;
                        mem_size   <= 2'd2;
                        mem_wstrb  <= 4'd0;
                        mem_addr   <= inst_addr;
                        mem_wdata  <= 32'd0;
                        owner_data <= 1'b0;
                        streak     <= 4'd0;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_ISSUE;
                    end else if (grant_data) begin
                        mem_wr     <= data_wr;
                        mem_size   <= data_size;
                        mem_wstrb  <= data_wstrb;
                        mem_addr   <= data_addr;
                        mem_wdata  <= data_wdata;
                        owner_data <= 1'b1;
                        // Only a grant that beat a waiting fetch counts
                        // toward the streak.
                        if (inst_req && (streak != STREAK_MAX)) begin
                            streak <= streak + 4'd1;
                        end
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_q <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
